// File: rtl/io_pkg.sv
// Shared constants and types for the IO input port: word width, FIFO depth,
// and the word/occupancy types derived from them.
package io_pkg;
  localparam int IO_DATA_W     = 32;
  localparam int IO_FIFO_DEPTH = 4;

  typedef logic [IO_DATA_W-1:0]                io_word_t;
  typedef logic [$clog2(IO_FIFO_DEPTH+1)-1:0]  io_cnt_t;
endpackage

// File: rtl/io_input_port_if.sv
// Device-side and core-side signals of the IO input port. The optional
// underflow error pair exists only when IO_IN_UNDERFLOW_ERR_EN is defined.
interface io_input_port_if
  import io_pkg::*;
#(
  parameter int DATA_W = IO_DATA_W,
  parameter int DEPTH  = IO_FIFO_DEPTH
);
  logic                         ext_valid;
  logic [DATA_W-1:0]            ext_data;
  logic                         ext_ready;
  logic                         io_req;
  logic                         io_pop;
  logic [DATA_W-1:0]            io_data;
  logic                         io_avail;
  logic                         io_stall;
  logic [$clog2(DEPTH+1)-1:0]   io_count;
`ifdef IO_IN_UNDERFLOW_ERR_EN
  logic                         io_err;
  logic                         io_err_clr;
`endif

  // Driver side: external device plus decode stage.
  modport master (
    output ext_valid, ext_data, io_req, io_pop,
`ifdef IO_IN_UNDERFLOW_ERR_EN
    output io_err_clr,
    input  io_err,
`endif
    input  ext_ready, io_data, io_avail, io_stall, io_count
  );

  // The port itself.
  modport slave (
    input  ext_valid, ext_data, io_req, io_pop,
`ifdef IO_IN_UNDERFLOW_ERR_EN
    input  io_err_clr,
    output io_err,
`endif
    output ext_ready, io_data, io_avail, io_stall, io_count
  );
endinterface

// File: rtl/io_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write port, asynchronous read
// port, used as the show-ahead FIFO storage.
module io_fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset; occupancy gates every read, so stale contents
  // are never observed and the array maps onto plain flops or LUT RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/io_input_port.sv
// IO input port: show-ahead FIFO between an external device and the decode
// write mux. Define IO_IN_UNDERFLOW_ERR_EN for a sticky underflow flag.
module io_input_port
  import io_pkg::*;
#(
  parameter int DATA_W = IO_DATA_W,
  parameter int DEPTH  = IO_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  io_input_port_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  // Status derives from registered count only, so ext_ready never sees io_pop.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.ext_valid & ~full;
  assign pop   = bus.io_pop & ~empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  io_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (bus.ext_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign bus.ext_ready = ~full;
  assign bus.io_avail  = ~empty;
  assign bus.io_data   = empty ? '0 : head;
  assign bus.io_stall  = bus.io_req & empty;
  assign bus.io_count  = count;

`ifdef IO_IN_UNDERFLOW_ERR_EN
  logic err_q;

  // Set has priority over clear when both land in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   err_q <= 1'b0;
    else if (bus.io_pop && empty) err_q <= 1'b1;
    else if (bus.io_err_clr)      err_q <= 1'b0;
  end

  assign bus.io_err = err_q;
`endif
endmodule
